// File: rtl/spsram_bank_pkg.sv
// Shared constants, derived-width helpers and round-robin port IDs for the
// banked single-port SRAM.
package spsram_bank_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 1024;
  localparam int NB_DEF    = 4;

  // Bank-select bits (NB must be a power of two).
  function automatic int calc_bw(input int nb);
    return $clog2(nb);
  endfunction

  // Word-address width covering every word of every bank.
  function automatic int calc_aw(input int nb, input int depth);
    return $clog2(nb * depth);
  endfunction

  // One byte-enable bit per data byte.
  function automatic int calc_bew(input int dw);
    return dw / 8;
  endfunction

  // Port IDs held in the round-robin pointer.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/spsram_bank_arb_if.sv
// Request/response bundle for one requester of the banked SRAM.
interface spsram_bank_arb_if #(
  parameter int DW = spsram_bank_pkg::DW_DEF,
  parameter int AW = spsram_bank_pkg::calc_aw(spsram_bank_pkg::NB_DEF,
                                              spsram_bank_pkg::DEPTH_DEF)
);
  logic            valid;
  logic            ready;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/spsram_be.sv
// One single-port SRAM bank: byte-enable write, registered read.
module spsram_be
  import spsram_bank_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [calc_bew(DW)-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout
);
  localparam int BEW = calc_bew(DW);

  logic [DW-1:0] mem [DEPTH];

  // Access port: per-byte write or registered read, one per cycle.
  // NOTE: the array has no reset so it maps onto SRAM macros; contents survive rst.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < BEW; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spsram_bank_arb.sv
// Two-port front end for NB interleaved single-port banks: round-robin
// arbitration on same-bank collisions, per-bank request mux and per-port
// read-response steering.
module spsram_bank_arb
  import spsram_bank_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NB    = NB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  spsram_bank_arb_if.slave a_if,
  spsram_bank_arb_if.slave b_if
);
  localparam int BW = calc_bw(NB);
  localparam int AW = calc_aw(NB, DEPTH);
  localparam int RW = AW - BW;

  logic [BW-1:0] a_bank, b_bank;
  logic [RW-1:0] a_row, b_row;
  logic          conflict, a_acc, b_acc;
  port_e         rr_q, rr_d;
  logic [DW-1:0] bank_dout [NB];

  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [BW-1:0] a_rbank_q, a_rbank_d, b_rbank_q, b_rbank_d;
  logic [DW-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic [DW-1:0] a_resp, b_resp;

  assign a_bank = a_if.addr[BW-1:0];
  assign b_bank = b_if.addr[BW-1:0];
  assign a_row  = a_if.addr[AW-1:BW];
  assign b_row  = b_if.addr[AW-1:BW];

  // Only a same-bank collision stalls anyone; the pointer picks the winner.
  assign conflict   = a_if.valid & b_if.valid & (a_bank == b_bank);
  assign a_if.ready = ~conflict | (rr_q == PORT_A);
  assign b_if.ready = ~conflict | (rr_q == PORT_B);
  assign a_acc      = a_if.valid & a_if.ready;
  assign b_acc      = b_if.valid & b_if.ready;

  // Per-bank request mux: at most one accepted port targets a given bank.
  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic a_sel, b_sel;
    assign a_sel = a_acc & (a_bank == BW'(g));
    assign b_sel = b_acc & (b_bank == BW'(g));

    spsram_be #(.DW(DW), .DEPTH(DEPTH)) u_bank (
      .clk  (clk),
      .en   (a_sel | b_sel),
      .we   (a_sel ? a_if.we    : b_if.we),
      .be   (a_sel ? a_if.be    : b_if.be),
      .addr (a_sel ? a_row      : b_row),
      .din  (a_sel ? a_if.wdata : b_if.wdata),
      .dout (bank_dout[g])
    );
  end

  assign a_resp = bank_dout[a_rbank_q];
  assign b_resp = bank_dout[b_rbank_q];

  // Next state: pointer hands priority to the loser, responses track accepted reads.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rr_d = rr_q;
    if (conflict) rr_d = (rr_q == PORT_A) ? PORT_B : PORT_A;
    a_rvalid_d = a_acc & ~a_if.we;
    b_rvalid_d = b_acc & ~b_if.we;
    a_rbank_d  = a_rvalid_d ? a_bank : a_rbank_q;
    b_rbank_d  = b_rvalid_d ? b_bank : b_rbank_q;
    a_hold_d   = a_rvalid_q ? a_resp : a_hold_q;
    b_hold_d   = b_rvalid_q ? b_resp : b_hold_q;
  end

  // State registers with synchronous reset; bank contents are untouched.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= PORT_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rbank_q  <= '0;
      b_rbank_q  <= '0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rbank_q  <= a_rbank_d;
      b_rbank_q  <= b_rbank_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
    end
  end

  // A read in flight when rst arrives is dropped, so rvalid is masked during rst.
  assign a_if.rvalid = a_rvalid_q & ~rst;
  assign b_if.rvalid = b_rvalid_q & ~rst;
  assign a_if.rdata  = a_if.rvalid ? a_resp : a_hold_q;
  assign b_if.rdata  = b_if.rvalid ? b_resp : b_hold_q;

endmodule

// File: doc/spsram_bank_arb.md
Name: spsram_bank_arb

Overview:
Dual-requester banked single-port SRAM. Two independent ports (A, B) share NB single-port banks, with low-order address interleaving. Each port uses a valid/ready request handshake, byte-enable writes and a registered read response. Same-bank collisions are resolved by a round-robin arbiter. Different-bank accesses proceed in parallel. Sits between two bus masters (e.g. fetch + load/store) and on-chip memory.

Parameters:
DW, 32, data width in bits; multiple of 8
DEPTH, 1024, words per bank
NB, 4, number of banks; power of two, >= 2
BW, $clog2(NB), bank-select bits (derived)
AW, $clog2(NB*DEPTH), word address width (derived)
BEW, DW/8, byte-enable width (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
a_valid  in  1  port A request valid
a_ready  out  1  port A request accepted this cycle
a_we  in  1  1 = write, 0 = read
a_addr  in  AW  word address; bank = a_addr[BW-1:0], row = a_addr[AW-1:BW]
a_wdata  in  DW  write data
a_be  in  BEW  byte enables for writes; ignored on reads
a_rvalid  out  1  read data valid
a_rdata  out  DW  read data
b_*  same set as a_*, for port B

Behaviour:
- Reset (one clk with rst=1):
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - Round-robin pointer = A.
  - Memory contents are not cleared.
- Handshake:
  - A request is accepted in the cycle where valid & ready are both 1.
  - A master with valid=1 and ready=0 must hold we/addr/wdata/be stable until accepted.
  - ready is combinational from both valids, both bank fields and the RR pointer. No combinational path from ready to valid.
- Arbitration:
  - Bank conflict = a_valid & b_valid & (a bank == b bank).
  - No conflict: both ready = 1 (an idle port also shows ready = 1).
  - Conflict: the port named by the RR pointer wins. The loser sees ready = 0.
  - The pointer flips to the loser only on a cycle with a conflict; otherwise it is unchanged.
  - Two consecutive conflicts therefore alternate A, B, A...; neither port starves.
- Memory access: the accepted request drives its bank in that cycle.
  - Write: bytes with be[k] = 1 are updated at the row; bytes with be=0 are preserved. be = 0 is a legal no-op that is still accepted.
  - Read: data is registered. Accepted at edge T, x_rvalid = 1 and x_rdata valid for exactly one cycle after edge T+1 (latency 1).
  - Writes produce no response.
- Output steering: each port records its accepted bank index in a 1-cycle pipeline register and muxes that bank's output. Port responses are independent and in-order by construction.
- rdata outside rvalid:
  - Holds its last value; never X after reset.
  - Read-back data is X until the word has been written.
- Read-during-write, same bank: impossible in one cycle (only one access per bank per cycle).
- Serialized A-write then B-read of the same address: B returns the new data.
- Reset mid-operation:
  - An in-flight read (accepted the cycle before rst) is dropped; rvalid stays 0.
  - A write accepted in the same cycle as rst is still committed. The memory array ignores rst.
- Address out of range: cannot occur (AW exactly covers NB*DEPTH).

Decomposition:
- Package spsram_bank_pkg: default DW, DEPTH and NB constants; localparam functions for BW, AW and BEW; port-ID constants PORT_A = 0, PORT_B = 1 for the RR pointer.
- Sub-module spsram_be: one bank with byte-enable write and registered read.
  - Ports: clk, en, we, be[BEW], addr[$clog2(DEPTH)], din, dout.
  - Instantiated NB times by a generate loop.
  - Top level holds the arbiter, the per-bank request mux and the response steering.

Test Plan:
1. Parallel, different banks: A writes 0x11223344 to addr 0 (bank 0) while B writes 0xAABBCCDD to addr 1 (bank 1), same cycle, be=4'hF -> both ready=1. Next cycle both read back -> a_rdata=0x11223344, b_rdata=0xAABBCCDD, both rvalid one cycle later.
2. Same-bank conflict after reset: A reads addr 4 and B reads addr 8 (both bank 0), valids held -> cycle 0: a_ready=1, b_ready=0; cycle 1: b_ready=1; a_rvalid at cycle 1, b_rvalid at cycle 2.
3. Sustained conflict: both ports stream 6 reads to bank 2 -> grants alternate A,B,A,B,A,B; each port gets 3 grants; no port waits more than 1 cycle.
4. Byte enables: write 0xFFFFFFFF to addr 3, then 0x00000000 with be=4'b0101, read addr 3 -> rdata=0xFF00FF00.
5. Write-then-read ordering: A writes 0xDEADBEEF to addr 12 and B reads addr 12, with A holding priority -> B is granted one cycle later and returns 0xDEADBEEF.
6. Reset mid-read: accept a read at edge T, assert rst for cycle T+1 -> rvalid stays 0. After reset the RR pointer is A, and earlier-written data is still readable.
